// File: rtl/csub_pkg.sv
// Shared types and sizing helpers for the word-serial conditional subtractor.
// Latency: n/a (package). Backpressure: n/a.
// Holds the FSM state encoding and the default datapath geometry.
package csub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUB   = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam int CSUB_WORD   = 8;
    localparam int CSUB_NWORDS = 4;
    localparam int W           = CSUB_WORD * CSUB_NWORDS;

    // Word-index width; never narrower than one bit so a single-word build still has a counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cla_adder.sv
// K-bit carry-lookahead adder: sum = a + b + cin, with carry out.
// Latency: combinational. Backpressure: none.
// Carries are formed from per-bit generate/propagate terms.
module cla_adder #(
    parameter int K = 8
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         cin,
    output logic [K-1:0] sum,
    output logic         cout
);

    logic [K-1:0] g;
    logic [K-1:0] p;
    logic [K:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < K; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum  = p ^ c[K-1:0];
    assign cout = c[K];

endmodule

// File: rtl/csub_reduce_ctrl.sv
// Word-serial final conditional subtraction: result = (T >= M) ? T - M : T. Optional macro CSUB_START_QUEUE_EN.
// Latency: o_done rises NWORDS+1 edges after the accepting start edge.
// Backpressure: o_ready gates i_start; with CSUB_START_QUEUE_EN one extra request is buffered while busy.
module csub_reduce_ctrl
    import csub_pkg::*;
#(
    parameter int WORD   = CSUB_WORD,
    parameter int NWORDS = CSUB_NWORDS
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [WORD*NWORDS:0]     i_T,
    input  logic [WORD*NWORDS-1:0]   i_M,
    output logic                     o_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [WORD*NWORDS-1:0]   o_result,
    output logic                     o_ge
);

    localparam int DW = WORD * NWORDS;
    localparam int IW = clog2(NWORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [DW:0]   t_q;
    logic [DW-1:0] m_q;
    logic [DW-1:0] diff_q;

    logic [WORD-1:0] t_word;
    logic [WORD-1:0] m_word_n;
    logic [WORD-1:0] sum_word;
    logic            cout_word;
    logic            ge;

    assign t_word   = t_q[int'(idx)*WORD +: WORD];
    assign m_word_n = ~m_q[int'(idx)*WORD +: WORD];
    // Overflow MSB forces the subtraction; otherwise the final not-borrow decides.
    assign ge       = t_q[DW] | carry;

    cla_adder #(.K(WORD)) u_add (
        .a    (t_word),
        .b    (m_word_n),
        .cin  (carry),
        .sum  (sum_word),
        .cout (cout_word)
    );

`ifdef CSUB_START_QUEUE_EN
    logic          pend_valid;
    logic [DW:0]   pend_t;
    logic [DW-1:0] pend_m;

    assign o_ready = ~pend_valid | (state == IDLE);
`else
    assign o_ready = (state == IDLE);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b1;
            t_q      <= '0;
            m_q      <= '0;
            diff_q   <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_result <= '0;
            o_ge     <= 1'b0;
`ifdef CSUB_START_QUEUE_EN
            pend_valid <= 1'b0;
            pend_t     <= '0;
            pend_m     <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        t_q    <= i_T;
                        m_q    <= i_M;
                        idx    <= '0;
                        carry  <= 1'b1;
                        o_busy <= 1'b1;
                        state  <= SUB;
                    end
                end
                SUB: begin
                    diff_q[int'(idx)*WORD +: WORD] <= sum_word;
                    carry <= cout_word;
                    if (idx == LAST_IDX) begin
                        state <= FINAL;
                    end else begin
                        idx <= idx + 1'b1;
                    end
`ifdef CSUB_START_QUEUE_EN
                    if (i_start && !pend_valid) begin
                        pend_valid <= 1'b1;
                        pend_t     <= i_T;
                        pend_m     <= i_M;
                    end
`endif
                end
                FINAL: begin
                    o_result <= ge ? diff_q : t_q[DW-1:0];
                    o_ge     <= ge;
                    o_done   <= 1'b1;
                    idx      <= '0;
                    carry    <= 1'b1;
`ifdef CSUB_START_QUEUE_EN
                    // Chain straight into the next operation so the core never idles between results.
                    if (pend_valid) begin
                        t_q        <= pend_t;
                        m_q        <= pend_m;
                        pend_valid <= 1'b0;
                        state      <= SUB;
                    end else if (i_start) begin
                        t_q   <= i_T;
                        m_q   <= i_M;
                        state <= SUB;
                    end else begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
`else
                    o_busy <= 1'b0;
                    state  <= IDLE;
`endif
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csub_reduce_ctrl.sv
// Directed bench for csub_reduce_ctrl with WORD=8, NWORDS=2 (16-bit modulus).
// Expected values are hand-computed constants.
module tb_csub_reduce_ctrl;

    localparam int WORD   = 8;
    localparam int NWORDS = 2;
    localparam int DW     = WORD * NWORDS;
    localparam int LAT    = NWORDS + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [DW:0]   t_in = '0;
    logic [DW-1:0] m_in = '0;
    logic          ready;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic          ge;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csub_reduce_ctrl #(.WORD(WORD), .NWORDS(NWORDS)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_T      (t_in),
        .i_M      (m_in),
        .o_ready  (ready),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result),
        .o_ge     (ge)
    );

    // Presents a start for one edge; returns at the falling edge after acceptance with inputs scrambled.
    task automatic start_op(input logic [DW:0] t, input logic [DW-1:0] m);
        @(negedge clk);
        t_in  = t;
        m_in  = m;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        t_in  = ~t;
        m_in  = ~m;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [DW:0] t, input logic [DW-1:0] m, output int lat,
                          output logic busy0, output logic ge_o, output logic [DW-1:0] res_o);
        start_op(t, m);
        busy0 = busy;
        wait_done(lat);
        ge_o  = ge;
        res_o = result;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got=%h want=0000", result); end
        checks++; if (ge !== 1'b0) begin errors++; $display("FAIL reset_ge got=%b want=0", ge); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_op(input string name, input logic [DW:0] t, input logic [DW-1:0] m,
                           input logic exp_ge, input logic [DW-1:0] exp_res);
        int n;
        logic b0, g;
        logic [DW-1:0] r;
        run_op(t, m, n, b0, g, r);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL %s_busy got=%b want=1", name, b0); end
        checks++; if (n != LAT) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", name, n, LAT); end
        checks++; if (g !== exp_ge) begin errors++; $display("FAIL %s_ge got=%b want=%b", name, g, exp_ge); end
        checks++; if (r !== exp_res) begin errors++; $display("FAIL %s_result got=%h want=%h", name, r, exp_res); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s_after done=%b busy=%b want=0/0", name, done, busy);
        end
        checks++; if (result !== exp_res) begin errors++; $display("FAIL %s_hold got=%h want=%h", name, result, exp_res); end
    endtask

    task automatic test_less;   test_op("less",   17'h00FFF, 16'h1234, 1'b0, 16'h0FFF); endtask
    task automatic test_equal;  test_op("equal",  17'h01234, 16'h1234, 1'b1, 16'h0000); endtask
    task automatic test_borrow; test_op("borrow", 17'h01300, 16'h12FF, 1'b1, 16'h0001); endtask
    task automatic test_msb;    test_op("msb",    17'h12000, 16'hF000, 1'b1, 16'h3000); endtask

    task automatic test_reset_midop;
        int seen;
        start_op(17'h00FFF, 16'h1234);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b want=0", done); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL midrst_result got=%h want=0000", result); end
        checks++; if (ge !== 1'b0) begin errors++; $display("FAIL midrst_ge got=%b want=0", ge); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_stale_done got=%0d want=0", seen); end
        test_op("midrst_fresh", 17'h01300, 16'h12FF, 1'b1, 16'h0001);
    endtask

    task automatic test_back_to_back;
        int n1, n2, dones, busy_low;
        start_op(17'h00FFF, 16'h1234);
        @(negedge clk);
`ifdef CSUB_START_QUEUE_EN
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b want=1", ready); end
`else
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got=%b want=0", ready); end
`endif
        t_in  = 17'h01300;
        m_in  = 16'h12FF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t_in  = '0;
        m_in  = '0;
`ifdef CSUB_START_QUEUE_EN
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got=%b want=0", ready); end
`endif
        wait_done(n1);
        checks++; if (n1 != 1) begin errors++; $display("FAIL b2b_first_latency got=%0d want=1", n1); end
        checks++; if (result !== 16'h0FFF || ge !== 1'b0) begin
            errors++; $display("FAIL b2b_first got=%h/%b want=0fff/0", result, ge);
        end
`ifdef CSUB_START_QUEUE_EN
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_at_done got=%b want=1", busy); end
        n2 = 0;
        busy_low = 0;
        do begin
            @(negedge clk);
            n2++;
            if (done !== 1'b1 && busy !== 1'b1) busy_low++;
        end while (done !== 1'b1 && n2 < 40);
        checks++; if (n2 != LAT) begin errors++; $display("FAIL b2b_second_latency got=%0d want=%0d", n2, LAT); end
        checks++; if (busy_low != 0) begin errors++; $display("FAIL b2b_busy_gap got=%0d want=0", busy_low); end
        checks++; if (result !== 16'h0001 || ge !== 1'b1) begin
            errors++; $display("FAIL b2b_second got=%h/%b want=0001/1", result, ge);
        end
`else
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_at_done got=%b want=0", busy); end
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL b2b_extra_done got=%0d want=0", dones); end
        checks++; if (result !== 16'h0FFF) begin errors++; $display("FAIL b2b_held got=%h want=0fff", result); end
`endif
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_less;
        test_equal;
        test_borrow;
        test_msb;
        test_reset_midop;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csub_reduce_ctrl.md
Name: csub_reduce_ctrl

Overview:
- Word-serial final conditional subtraction for the Montgomery multiplier.
- Returns T - M when T >= M, otherwise T. Input T is W+1 bits, with T < 2M.
- Sequences one WORD-bit subtract datapath over NWORDS cycles, propagating the not-borrow carry between words.
- Sits between the Montgomery core's result register and the output register.

Parameters:
- WORD, 8, datapath word width (K of the subtract adder).
- NWORDS, 4, number of words; W = WORD*NWORDS.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  request; accepted when o_ready=1.
- i_T  in  W+1  unreduced result; bit W is the overflow MSB.
- i_M  in  W  modulus.
- o_ready  in/out: output  1  start can be accepted this cycle.
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle pulse; o_result is valid from this cycle on.
- o_result  out  W  reduced value; held until the next completion.
- o_ge  out  1  1 when T >= M (subtraction taken); held with o_result.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; o_busy=0, o_done=0, o_result=0, o_ge=0; idx=0; carry=1; internal T/M/diff registers cleared. An in-flight operation is discarded.
- Without CSUB_START_QUEUE_EN, o_ready = (state==IDLE).
- IDLE:
  - On a clock edge with i_start=1 and o_ready=1: latch i_T and i_M, set idx=0, carry=1, go to SUB. o_busy is 1 from the next cycle.
  - i_start when not ready: ignored.
- SUB:
  - Each edge computes diff_word = T[idx] + ~M[idx] + carry.
  - Stores Sum into diff[idx]; carry <= Cout.
  - If idx==NWORDS-1, go to FINAL; otherwise idx++.
  - Exactly NWORDS cycles.
- FINAL (one cycle):
  - ge = T[W] | carry.
  - o_result <= ge ? diff : T[W-1:0]; o_ge <= ge; o_done <= 1 for one cycle.
  - Go to IDLE; o_busy falls with o_done.
- Latency: start edge to o_done high is NWORDS+1 edges. Throughput is one op per NWORDS+2 cycles.
- Arithmetic:
  - Modulo 2^W on diff.
  - Equality T==M gives ge=1, result 0.
  - T[W]=1 always takes the subtraction.
  - T >= 2M is out of contract; the result is T-M truncated, with no flag.
- i_T and i_M may change freely after acceptance.
- o_result and o_ge change only in FINAL.

Optional Feature:
- Macro CSUB_START_QUEUE_EN.
- With it:
  - One-deep pending buffer (pend_valid, pend_T, pend_M).
  - o_ready = ~pend_valid | (state==IDLE).
  - An i_start accepted while busy loads the pending buffer.
  - In FINAL with pend_valid=1, the pending operands load directly, state goes to SUB next (not IDLE), and pend_valid clears. o_busy stays 1.
  - i_start while pend_valid=1 and busy: ignored.
  - Reset clears pend_valid.
- Without it: no buffer; o_ready = idle; starts while busy are dropped.

Decomposition:
- Package csub_pkg holds:
  - state enum: IDLE, SUB, FINAL (2 bits);
  - localparam W;
  - idx width function clog2(NWORDS).
- Datapath: instantiate the existing cla_adder with K=WORD, B=~M word and Cin=carry register. Do not use k_bit_subtractor, whose Cin is fixed at 1.
- No further sub-module; the word mux and select live in the controller.

Test Plan:
- All tests use WORD=8, NWORDS=2.
- T=0x00FFF, M=0x1234, start -> o_done exactly 3 edges later, o_ge=0, o_result=0x0FFF.
- T=0x01234, M=0x1234 -> o_ge=1, o_result=0x0000 (equality boundary).
- T=0x01300, M=0x12FF -> cross-word borrow handled; o_ge=1, o_result=0x0001.
- T=0x12000 (MSB set), M=0xF000 -> o_ge=1, o_result=0x3000.
- i_rst_n low on the second SUB cycle -> o_busy=0, o_done=0, o_result=0 immediately. A fresh start then completes normally.
- Second start while busy:
  - without CSUB_START_QUEUE_EN: ignored, single o_done;
  - with it: o_ready=1, second o_done exactly NWORDS+1 edges after the first, o_busy continuously high.
